// File: rtl/score_ctrl_if.sv
// Score controller bus: game event pulses in, score/display state out.
interface score_ctrl_if;
    logic       start;
    logic       pass;
    logic       crash;
    logic       frame_start;
    logic [1:0] game_state;
    logic [9:0] score;
    logic [9:0] high_score;
    logic       new_high;
    logic [3:0] disp_d2;
    logic [3:0] disp_d1;
    logic [3:0] disp_d0;
    logic       busy;
    logic       done;

    modport master (
        output start, pass, crash, frame_start,
        input  game_state, score, high_score, new_high,
        input  disp_d2, disp_d1, disp_d0, busy, done
    );

    modport slave (
        input  start, pass, crash, frame_start,
        output game_state, score, high_score, new_high,
        output disp_d2, disp_d1, disp_d0, busy, done
    );
endinterface

// File: rtl/score_ctrl.sv
// Game score keeper with a per-frame binary-to-BCD (double dabble)
// converter feeding a tear-free three-digit display latch.
module score_ctrl #(
    parameter int unsigned MAX_SCORE = 999,
    parameter int unsigned CONV_BITS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    score_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PLAYING = 2'b01;
    localparam logic [1:0] ST_OVER    = 2'b10;

    localparam logic [1:0] CONV_IDLE  = 2'b00;
    localparam logic [1:0] SHIFT      = 2'b01;
    localparam logic [1:0] DONE       = 2'b10;

    localparam logic [CONV_BITS-1:0] W_MAX = CONV_BITS'(MAX_SCORE);
    localparam logic [3:0]           LAST  = 4'(CONV_BITS - 1);

    logic [1:0]           r_gstate;
    logic [CONV_BITS-1:0] r_score;
    logic [CONV_BITS-1:0] r_high;
    logic                 r_new_high;

    logic [1:0]           r_cstate;
    logic [CONV_BITS-1:0] r_bin;
    logic [11:0]          r_bcd;
    logic [3:0]           r_cnt;
    logic [3:0]           r_d2;
    logic [3:0]           r_d1;
    logic [3:0]           r_d0;
    logic                 r_busy;
    logic                 r_done;

    logic [CONV_BITS-1:0] w_src;
    logic [11:0]          w_bcd_adj;

    // Game FSM: start/crash sequencing, saturating score, high-score capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gstate   <= ST_IDLE;
            r_score    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else begin
            case (r_gstate)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        r_gstate   <= ST_PLAYING;
                        r_score    <= '0;
                        r_new_high <= 1'b0;
                    end
                end
                ST_PLAYING: begin
                    // crash takes priority, so a coincident pass never counts
                    if (bus.crash) begin
                        r_gstate <= ST_OVER;
                        if (r_score > r_high) begin
                            r_high     <= r_score;
                            r_new_high <= 1'b1;
                        end
                    end else if (bus.pass && (r_score < W_MAX)) begin
                        r_score <= r_score + 1'b1;
                    end
                end
                default: r_gstate <= ST_IDLE;
            endcase
        end
    end

    // Pick what the display shows and precompute the add-3 correction.
    always_comb begin
        w_src = (r_gstate == ST_IDLE) ? r_high : r_score;
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: snapshot at frame_start, CONV_BITS dabble steps, latch digits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cstate <= CONV_IDLE;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_d2     <= '0;
            r_d1     <= '0;
            r_d0     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // busy trails the SHIFT state by one edge so it spans exactly the
            // ten cycles that follow each iteration edge
            r_busy <= (r_cstate == SHIFT);
            r_done <= 1'b0;
            case (r_cstate)
                CONV_IDLE: begin
                    if (bus.frame_start) begin
                        r_bin    <= w_src;
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_cstate <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= {w_bcd_adj[10:0], r_bin[CONV_BITS-1]};
                    r_bin <= {r_bin[CONV_BITS-2:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LAST) begin
                        r_cstate <= DONE;
                    end
                end
                DONE: begin
                    r_d2     <= r_bcd[11:8];
                    r_d1     <= r_bcd[7:4];
                    r_d0     <= r_bcd[3:0];
                    r_done   <= 1'b1;
                    r_cstate <= CONV_IDLE;
                end
                default: r_cstate <= CONV_IDLE;
            endcase
        end
    end

    assign bus.game_state = r_gstate;
    assign bus.score      = r_score;
    assign bus.high_score = r_high;
    assign bus.new_high   = r_new_high;
    assign bus.disp_d2    = r_d2;
    assign bus.disp_d1    = r_d1;
    assign bus.disp_d0    = r_d0;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed scenarios with literal expectations plus
// a randomized run, all cross-checked every cycle against a behavioural model.
module tb_score_ctrl;

    localparam int MAX = 999;

    logic clk;
    logic rst_n;
    score_ctrl_if bus();

    score_ctrl #(.MAX_SCORE(999), .CONV_BITS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    int m_gs, m_score, m_high, m_nh;
    int m_d2, m_d1, m_d0, m_busy, m_done;
    int m_conv = -1;
    int m_val;
    bit m_valid = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: game rules and an 11-edge conversion countdown using plain arithmetic.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_gs = 0; m_score = 0; m_high = 0; m_nh = 0;
            m_d2 = 0; m_d1 = 0; m_d0 = 0; m_busy = 0; m_done = 0;
            m_conv = -1;
            m_valid = 1;
        end else begin
            m_done = 0;
            if (m_conv < 0) begin
                if (bus.frame_start) begin
                    m_val  = (m_gs == 0) ? m_high : m_score;
                    m_conv = 0;
                end
            end else begin
                m_conv++;
                if (m_conv == 11) begin
                    m_d2 = m_val / 100;
                    m_d1 = (m_val / 10) % 10;
                    m_d0 = m_val % 10;
                    m_done = 1;
                    m_conv = -1;
                end
            end
            m_busy = (m_conv >= 1 && m_conv <= 10) ? 1 : 0;

            if (m_gs != 1) begin
                if (bus.start) begin
                    m_gs = 1; m_score = 0; m_nh = 0;
                end
            end else if (bus.crash) begin
                m_gs = 2;
                if (m_score > m_high) begin
                    m_high = m_score; m_nh = 1;
                end
            end else if (bus.pass) begin
                m_score = (m_score + 1 > MAX) ? MAX : m_score + 1;
            end
        end
    end

    // Compare every DUT output against the model just after each edge.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("game_state", 32'(bus.game_state), 32'(m_gs));
            check("score",      32'(bus.score),      32'(m_score));
            check("high_score", 32'(bus.high_score), 32'(m_high));
            check("new_high",   32'(bus.new_high),   32'(m_nh));
            check("disp_d2",    32'(bus.disp_d2),    32'(m_d2));
            check("disp_d1",    32'(bus.disp_d1),    32'(m_d1));
            check("disp_d0",    32'(bus.disp_d0),    32'(m_d0));
            check("busy",       32'(bus.busy),       32'(m_busy));
            check("done",       32'(bus.done),       32'(m_done));
        end
    end

    task automatic drive(input logic r, input logic s, input logic p, input logic c, input logic f);
        @(negedge clk);
        rst_n = r;
        bus.start = s;
        bus.pass = p;
        bus.crash = c;
        bus.frame_start = f;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_disp(input string name, input int d2, input int d1, input int d0);
        check({name, "_d2"}, 32'(bus.disp_d2), 32'(d2));
        check({name, "_d1"}, 32'(bus.disp_d1), 32'(d1));
        check({name, "_d0"}, 32'(bus.disp_d0), 32'(d0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.pass = 1'b0; bus.crash = 1'b0; bus.frame_start = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check("rst_gs",    32'(bus.game_state), 32'd0);
        check("rst_score", 32'(bus.score),      32'd0);
        check("rst_high",  32'(bus.high_score), 32'd0);
        check("rst_busy",  32'(bus.busy),       32'd0);
        check("rst_done",  32'(bus.done),       32'd0);
        check_disp("rst", 0, 0, 0);

        // seven passes then a conversion of 7
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (7) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 12; j++) begin
            idle();
            check("lat_busy", 32'(bus.busy), (j >= 2 && j <= 11) ? 32'd1 : 32'd0);
            check("lat_done", 32'(bus.done), (j == 12) ? 32'd1 : 32'd0);
        end
        check("seven_score", 32'(bus.score), 32'd7);
        check_disp("seven", 0, 0, 7);

        // saturation at the ceiling
        repeat (991) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        check("pre_sat", 32'(bus.score), 32'd998);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            idle();
            check("sat_score", 32'(bus.score), 32'd999);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (12) idle();
        check_disp("sat", 9, 9, 9);

        // pass and crash together at score 5
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        check("pc_gs",    32'(bus.game_state), 32'd2);
        check("pc_score", 32'(bus.score),      32'd5);
        check("pc_high",  32'(bus.high_score), 32'd5);
        check("pc_nh",    32'(bus.new_high),   32'd1);

        // second game ties the high score
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("g2_nh_clr", 32'(bus.new_high), 32'd0);
        repeat (5) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        check("tie_nh",   32'(bus.new_high),   32'd0);
        check("tie_high", 32'(bus.high_score), 32'd5);
        check("tie_gs",   32'(bus.game_state), 32'd2);

        // snapshot isolation and frame_start while busy
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (123) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (7) idle();
        check("snap_done",  32'(bus.done),  32'd1);
        check("snap_score", 32'(bus.score), 32'd124);
        check_disp("snap", 1, 2, 3);
        repeat (3) begin
            idle();
            check("snap_nobusy", 32'(bus.busy), 32'd0);
        end

        // reset in the middle of a conversion
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check_disp("abort", 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            idle();
            check("abort_nodone", 32'(bus.done), 32'd0);
        end

        // randomized traffic, checked by the model
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 8)  ? 1'b1 : 1'b0);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
